register_file: RTL and testbench

Parametrised multi-port register file: the successor to the single 8-bit register and the general-purpose register bank for the RISCyMCU datapath. It holds NUM_REGS words of BUS_WIDTH bits and has one write port and NUM_READ combinational read ports. Register 0 can optionally be hardwired to zero. A per-register written-since-clear mask serves debug and the context-save logic. All state updates on the falling edge of clk, so a value written in the first half of a cycle is readable in the second half.

---
 rtl/register_file_pkg.sv | 24 ++
 rtl/register_file_if.sv | 38 +++
 rtl/register_file_read_mux.sv | 25 ++
 rtl/register_file.sv | 77 +++++++
 tb/tb_register_file.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/register_file_pkg.sv
// register_file_pkg
// Shared constants and helpers for the register file and its interface.
//   BUS_WIDTH_DEF / NUM_REGS_DEF : default geometry of the register bank.
//   unpack_slice()                : extracts field <index> of <width> bits from
//                                   a packed multi-port vector.
package register_file_pkg;

  localparam int BUS_WIDTH_DEF = 8;
  localparam int NUM_REGS_DEF  = 8;

  // Widest packed vector / field the slice helper handles. Callers zero-extend
  // into RF_PACK_MAX bits and truncate the result back to their field width.
  localparam int RF_PACK_MAX  = 1024;
  localparam int RF_SLICE_MAX = 64;

  function automatic logic [RF_SLICE_MAX-1:0] unpack_slice(
    input logic [RF_PACK_MAX-1:0] packed_vec,
    input int                     index,
    input int                     width
  );
    return RF_SLICE_MAX'(packed_vec >> (index * width));
  endfunction

endpackage

// File: rtl/register_file_if.sv
// register_file_if
// Bus bundle between a register-file user (master) and the register file
// (slave).
//   write_control, active_enable : write request and block enable
//   wr_addr, wr_data             : write port
//   clear                        : synchronous clear-all
//   rd_addr                      : packed read addresses, port i at [i*ADDR_W +: ADDR_W]
//   rd_data                      : packed read data, port i at [i*BUS_WIDTH +: BUS_WIDTH]
//   dirty                        : per-register written-since-clear mask
interface register_file_if
  import register_file_pkg::*;
#(
  parameter int BUS_WIDTH = BUS_WIDTH_DEF,
  parameter int NUM_REGS  = NUM_REGS_DEF,
  parameter int NUM_READ  = 2
);
  localparam int ADDR_W = $clog2(NUM_REGS);

  logic                          write_control;
  logic                          active_enable;
  logic [ADDR_W-1:0]             wr_addr;
  logic [BUS_WIDTH-1:0]          wr_data;
  logic                          clear;
  logic [NUM_READ*ADDR_W-1:0]    rd_addr;
  logic [NUM_READ*BUS_WIDTH-1:0] rd_data;
  logic [NUM_REGS-1:0]           dirty;

  modport master (
    output write_control, active_enable, wr_addr, wr_data, clear, rd_addr,
    input  rd_data, dirty
  );

  modport slave (
    input  write_control, active_enable, wr_addr, wr_data, clear, rd_addr,
    output rd_data, dirty
  );

endinterface

// File: rtl/register_file_read_mux.sv
// regfile_read_mux
// One combinational read port: NUM_REGS:1 selection of a BUS_WIDTH word from
// the flattened register bank, with address 0 forced to zero when ZERO_REG=1.
//   words : all registers, register r at [r*BUS_WIDTH +: BUS_WIDTH]
//   sel   : register address
//   data  : selected word
module regfile_read_mux #(
  parameter int BUS_WIDTH = 8,
  parameter int NUM_REGS  = 8,
  parameter int ZERO_REG  = 1
) (
  input  logic [NUM_REGS*BUS_WIDTH-1:0] words,
  input  logic [$clog2(NUM_REGS)-1:0]   sel,
  output logic [BUS_WIDTH-1:0]          data
);

  always_comb begin
    data = words[int'(sel) * BUS_WIDTH +: BUS_WIDTH];
    // Register 0 storage still exists but is masked on every read.
    if ((ZERO_REG != 0) && (sel == '0)) begin
      data = '0;
    end
  end

endmodule

// File: rtl/register_file.sv
// register_file
// NUM_REGS x BUS_WIDTH register bank with one write port and NUM_READ
// combinational read ports. All state changes on the falling edge of clk so a
// value written in the first half of a cycle is readable in the second half.
//   clk : clock (state updates on falling edge)
//   rst : synchronous active-low reset, sampled on the falling edge
//   bus : register_file_if slave (write port, clear, read ports, dirty mask)
module register_file
  import register_file_pkg::*;
#(
  parameter int                   BUS_WIDTH   = BUS_WIDTH_DEF,
  parameter int                   NUM_REGS    = NUM_REGS_DEF,
  parameter int                   NUM_READ    = 2,
  parameter int                   ZERO_REG    = 1,
  parameter logic [BUS_WIDTH-1:0] RESET_VALUE = '0
) (
  input logic            clk,
  input logic            rst,
  register_file_if.slave bus
);

  localparam int ADDR_W = $clog2(NUM_REGS);

  logic                          we;
  logic [NUM_REGS*BUS_WIDTH-1:0] words;
  logic [NUM_REGS-1:0]           dirty_vec;
  logic [NUM_READ*BUS_WIDTH-1:0] rd_vec;

  assign we = bus.write_control & bus.active_enable;

  // One storage word plus dirty bit per register. Reset beats clear beats
  // write, so both reset and clear silently drop a concurrent write.
  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
    localparam bit WRITABLE = (ZERO_REG == 0) || (gi != 0);

    logic [BUS_WIDTH-1:0] word_reg;
    logic                 dirty_reg;

    always_ff @(negedge clk) begin
      if (!rst || bus.clear) begin
        word_reg  <= RESET_VALUE;
        dirty_reg <= 1'b0;
      end else if (WRITABLE && we && (bus.wr_addr == ADDR_W'(gi))) begin
        word_reg  <= bus.wr_data;
        dirty_reg <= 1'b1;
      end
    end

    assign words[gi*BUS_WIDTH +: BUS_WIDTH] = word_reg;
    assign dirty_vec[gi]                    = dirty_reg;
  end

  // Read ports read current storage directly: no write bypass, so a write
  // becomes visible only after the falling edge that commits it.
  for (genvar gi = 0; gi < NUM_READ; gi++) begin : g_rd
    logic [ADDR_W-1:0]    sel;
    logic [BUS_WIDTH-1:0] data;

    assign sel = ADDR_W'(unpack_slice(RF_PACK_MAX'(bus.rd_addr), gi, ADDR_W));

    regfile_read_mux #(
      .BUS_WIDTH (BUS_WIDTH),
      .NUM_REGS  (NUM_REGS),
      .ZERO_REG  (ZERO_REG)
    ) u_mux (
      .words (words),
      .sel   (sel),
      .data  (data)
    );

    assign rd_vec[gi*BUS_WIDTH +: BUS_WIDTH] = data;
  end

  assign bus.rd_data = rd_vec;
  assign bus.dirty   = dirty_vec;

endmodule

// File: tb/tb_register_file.sv
// tb_register_file
// Three register-file instances share clk/rst:
//   unit 0 (a): 8x8, 2 read ports, ZERO_REG=1
//   unit 1 (b): 8x8, 2 read ports, ZERO_REG=0 (driven identically to a)
//   unit 2 (c): 32x32, 3 read ports, ZERO_REG=1
// Stimulus pushes expected values into two queues: pre_q is compared 3 time
// units after the rising edge (before the falling edge that commits a write),
// post_q at the next rising edge (after that falling edge).
module tb_register_file;

  typedef struct {
    int          unit;
    int          port;   // -1 selects the dirty mask
    logic [31:0] exp;
    string       name;
  } chk_t;

  logic clk;
  logic rst;

  int checks   = 0;
  int failures = 0;

  chk_t pre_q[$];
  chk_t post_q[$];

  register_file_if #(.BUS_WIDTH(8),  .NUM_REGS(8),  .NUM_READ(2)) if_a ();
  register_file_if #(.BUS_WIDTH(8),  .NUM_REGS(8),  .NUM_READ(2)) if_b ();
  register_file_if #(.BUS_WIDTH(32), .NUM_REGS(32), .NUM_READ(3)) if_c ();

  register_file #(.BUS_WIDTH(8), .NUM_REGS(8), .NUM_READ(2), .ZERO_REG(1), .RESET_VALUE(8'h00))
    dut_a (.clk(clk), .rst(rst), .bus(if_a));
  register_file #(.BUS_WIDTH(8), .NUM_REGS(8), .NUM_READ(2), .ZERO_REG(0), .RESET_VALUE(8'h00))
    dut_b (.clk(clk), .rst(rst), .bus(if_b));
  register_file #(.BUS_WIDTH(32), .NUM_REGS(32), .NUM_READ(3), .ZERO_REG(1), .RESET_VALUE(32'h0))
    dut_c (.clk(clk), .rst(rst), .bus(if_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard helpers ----------------
  function automatic logic [31:0] actual(input int unit, input int port);
    logic [31:0] v;
    v = '0;
    if (unit == 0) begin
      if (port < 0) v = 32'(if_a.dirty);
      else          v = 32'(if_a.rd_data[port*8 +: 8]);
    end else if (unit == 1) begin
      if (port < 0) v = 32'(if_b.dirty);
      else          v = 32'(if_b.rd_data[port*8 +: 8]);
    end else begin
      if (port < 0) v = if_c.dirty;
      else          v = if_c.rd_data[port*32 +: 32];
    end
    return v;
  endfunction

  task automatic compare(input chk_t c);
    logic [31:0] act;
    act = actual(c.unit, c.port);
    checks++;
    if (act !== c.exp) begin
      failures++;
      $display("FAIL %s unit=%0d port=%0d actual=0x%0h required=0x%0h",
               c.name, c.unit, c.port, act, c.exp);
    end
  endtask

  task automatic exp_pre(input int unit, input int port, input logic [31:0] e, input string n);
    chk_t c;
    c.unit = unit; c.port = port; c.exp = e; c.name = n;
    pre_q.push_back(c);
  endtask

  task automatic exp_post(input int unit, input int port, input logic [31:0] e, input string n);
    chk_t c;
    c.unit = unit; c.port = port; c.exp = e; c.name = n;
    post_q.push_back(c);
  endtask

  // Monitor: decoupled from stimulus, drains each queue at its sample point.
  initial begin
    forever begin
      @(posedge clk);
      while (post_q.size() > 0) compare(post_q.pop_front());
      #3;
      while (pre_q.size() > 0) compare(pre_q.pop_front());
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_ab(input logic wc, input logic en, input logic [2:0] addr,
                          input logic [7:0] data, input logic clr);
    if_a.write_control = wc; if_a.active_enable = en; if_a.wr_addr = addr;
    if_a.wr_data = data; if_a.clear = clr;
    if_b.write_control = wc; if_b.active_enable = en; if_b.wr_addr = addr;
    if_b.wr_data = data; if_b.clear = clr;
  endtask

  task automatic rd_ab(input logic [2:0] a0, input logic [2:0] a1);
    if_a.rd_addr = {a1, a0};
    if_b.rd_addr = {a1, a0};
  endtask

  task automatic drive_c(input logic wc, input logic en, input logic [4:0] addr,
                         input logic [31:0] data, input logic clr);
    if_c.write_control = wc; if_c.active_enable = en; if_c.wr_addr = addr;
    if_c.wr_data = data; if_c.clear = clr;
  endtask

  task automatic rd_c(input logic [4:0] a0, input logic [4:0] a1, input logic [4:0] a2);
    if_c.rd_addr = {a2, a1, a0};
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed vectors ----------------
  initial begin
    rst = 1'b1;
    drive_ab(1'b0, 1'b0, 3'd0, 8'h00, 1'b0);
    rd_ab(3'd0, 3'd0);
    drive_c(1'b0, 1'b0, 5'd0, 32'h0, 1'b0);
    rd_c(5'd0, 5'd0, 5'd0);
    step();

    // Write 0x5A to r3 before any reset; r3 itself becomes defined.
    drive_ab(1'b1, 1'b1, 3'd3, 8'h5A, 1'b0);
    rd_ab(3'd3, 3'd3);
    exp_post(0, 0, 32'h5A, "a_r3_before_reset");
    exp_post(1, 1, 32'h5A, "b_r3_before_reset");
    step();

    // Reset for one falling edge.
    rst = 1'b0;
    drive_ab(1'b0, 1'b0, 3'd0, 8'h00, 1'b0);
    exp_post(0, 0, 32'h00, "a_r3_after_reset");
    exp_post(1, 1, 32'h00, "b_r3_after_reset");
    exp_post(0, -1, 32'h00, "a_dirty_reset");
    exp_post(1, -1, 32'h00, "b_dirty_reset");
    exp_post(2, -1, 32'h0, "c_dirty_reset");
    step();
    rst = 1'b1;

    // Every register reads 0 after reset.
    for (int i = 0; i < 4; i++) begin
      rd_ab(3'(2*i), 3'(2*i+1));
      exp_post(0, 0, 32'h00, "a_reset_even");
      exp_post(0, 1, 32'h00, "a_reset_odd");
      exp_post(1, 0, 32'h00, "b_reset_even");
      exp_post(1, 1, 32'h00, "b_reset_odd");
      step();
    end
    rd_c(5'd0, 5'd1, 5'd31);
    exp_post(2, 0, 32'h0, "c_reset_r0");
    exp_post(2, 1, 32'h0, "c_reset_r1");
    exp_post(2, 2, 32'h0, "c_reset_r31");
    step();

    // Write then read: old value before the falling edge, new after.
    drive_ab(1'b1, 1'b1, 3'd5, 8'hA7, 1'b0);
    rd_ab(3'd5, 3'd5);
    exp_pre(0, 0, 32'h00, "a_r5_before_edge");
    exp_pre(1, 0, 32'h00, "b_r5_before_edge");
    exp_post(0, 0, 32'hA7, "a_r5_port0");
    exp_post(0, 1, 32'hA7, "a_r5_port1");
    exp_post(1, 0, 32'hA7, "b_r5_port0");
    exp_post(0, -1, 32'h20, "a_dirty_r5");
    exp_post(1, -1, 32'h20, "b_dirty_r5");
    step();

    // Enable gating: either control low blocks the write.
    drive_ab(1'b1, 1'b0, 3'd2, 8'hFF, 1'b0);
    rd_ab(3'd2, 3'd5);
    exp_post(0, 0, 32'h00, "a_r2_en_low");
    exp_post(0, 1, 32'hA7, "a_r5_held");
    exp_post(0, -1, 32'h20, "a_dirty_en_low");
    step();
    drive_ab(1'b0, 1'b1, 3'd2, 8'hFF, 1'b0);
    exp_post(0, 0, 32'h00, "a_r2_wc_low");
    exp_post(1, 0, 32'h00, "b_r2_wc_low");
    exp_post(0, -1, 32'h20, "a_dirty_wc_low");
    step();

    // Zero register: dropped on a, ordinary on b.
    drive_ab(1'b1, 1'b1, 3'd0, 8'h33, 1'b0);
    rd_ab(3'd0, 3'd0);
    exp_post(0, 0, 32'h00, "a_r0_port0");
    exp_post(0, 1, 32'h00, "a_r0_port1");
    exp_post(0, -1, 32'h20, "a_dirty_r0");
    exp_post(1, 0, 32'h33, "b_r0_port0");
    exp_post(1, -1, 32'h21, "b_dirty_r0");
    step();

    // Clear wins over a concurrent write.
    drive_ab(1'b1, 1'b1, 3'd1, 8'h11, 1'b1);
    rd_ab(3'd1, 3'd5);
    exp_post(0, 0, 32'h00, "a_r1_clear_write");
    exp_post(0, 1, 32'h00, "a_r5_cleared");
    exp_post(0, -1, 32'h00, "a_dirty_clear");
    exp_post(1, -1, 32'h00, "b_dirty_clear");
    step();

    // Back-to-back writes to r1: last one wins.
    drive_ab(1'b1, 1'b1, 3'd1, 8'h11, 1'b0);
    exp_post(0, 0, 32'h11, "a_r1_first");
    step();
    drive_ab(1'b1, 1'b1, 3'd1, 8'h22, 1'b0);
    exp_pre(0, 0, 32'h11, "a_r1_old_before_edge");
    exp_post(0, 0, 32'h22, "a_r1_second");
    exp_post(1, 0, 32'h22, "b_r1_second");
    exp_post(0, -1, 32'h02, "a_dirty_r1");
    step();

    // Reset together with clear and a write.
    rst = 1'b0;
    drive_ab(1'b1, 1'b1, 3'd4, 8'h44, 1'b1);
    rd_ab(3'd1, 3'd4);
    exp_post(0, 0, 32'h00, "a_r1_rst_clear_write");
    exp_post(0, 1, 32'h00, "a_r4_rst_clear_write");
    exp_post(1, 1, 32'h00, "b_r4_rst_clear_write");
    exp_post(0, -1, 32'h00, "a_dirty_rst_clear");
    step();
    rst = 1'b1;
    drive_ab(1'b0, 1'b0, 3'd0, 8'h00, 1'b0);

    // Wide multi-port instance.
    drive_c(1'b1, 1'b1, 5'd31, 32'hDEADBEEF, 1'b0);
    step();
    drive_c(1'b1, 1'b1, 5'd7, 32'h12345678, 1'b0);
    rd_c(5'd31, 5'd7, 5'd31);
    exp_pre(2, 1, 32'h0, "c_r7_before_edge");
    exp_post(2, 0, 32'hDEADBEEF, "c_port0_r31");
    exp_post(2, 1, 32'h12345678, "c_port1_r7");
    exp_post(2, 2, 32'hDEADBEEF, "c_port2_r31");
    exp_post(2, -1, 32'h80000080, "c_dirty");
    step();
    drive_c(1'b0, 1'b0, 5'd0, 32'h0, 1'b1);
    exp_post(2, 2, 32'h0, "c_r31_cleared");
    exp_post(2, -1, 32'h0, "c_dirty_cleared");
    step();
    drive_c(1'b0, 1'b0, 5'd0, 32'h0, 1'b0);
    step();
    step();

    if (pre_q.size() != 0 || post_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_drain actual=%0d required=0",
               pre_q.size() + post_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
